// File: rtl/qft_row_sequencer_if.sv
// qft_row_sequencer_if: vector-in / amplitude-out handshake bundle for the QFT row sequencer
interface qft_row_sequencer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 13
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][IN_W-1:0]  in_r;
  logic [3:0][IN_W-1:0]  in_i;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [1:0]            out_idx;
  logic [OUT_W-1:0]      out_r;
  logic [OUT_W-1:0]      out_i;
  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_last, out_idx, out_r, out_i
  );
  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_last, out_idx, out_r, out_i
  );
endinterface

// File: rtl/qft_row_sequencer.sv
// qft_row_sequencer: 4-point QFT computed row by row on one time-shared complex MAC
module qft_row_sequencer #(
  parameter int IN_W    = 8,
  parameter int TW_W    = 12,
  parameter int TW_FRAC = 10,
  parameter int OUT_W   = 13,
  parameter int ACC_W   = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  qft_row_sequencer_if.slave  bus,
  output logic                busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  localparam logic signed [TW_W-1:0] ONE = TW_W'(1 << TW_FRAC);
  state_t                      state_q, state_d;
  logic [1:0]                  k_q, k_d, n_q, n_d, idx_q, idx_d;
  logic [3:0][IN_W-1:0]        xr_q, xr_d, xi_q, xi_d;
  logic signed [ACC_W-1:0]     acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic [OUT_W-1:0]            out_r_q, out_r_d, out_i_q, out_i_d;
  logic                        valid_q, valid_d, last_q, last_d;
  logic [1:0]                  m;
  logic signed [TW_W-1:0]      cos_w, sin_w;
  logic signed [ACC_W-1:0]     xr_e, xi_e, c_e, s_e, sum_r, sum_i;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign busy_o        = (state_q != IDLE);
  // twiddle lookup and one complex MAC step for column n of row k
  always_comb begin
    m     = 2'(k_q * n_q);
    cos_w = (m == 2'd0) ? ONE : (m == 2'd2) ? -ONE : '0;
    sin_w = (m == 2'd1) ? ONE : (m == 2'd3) ? -ONE : '0;
    xr_e  = ACC_W'($signed(xr_q[n_q]));
    xi_e  = ACC_W'($signed(xi_q[n_q]));
    c_e   = ACC_W'(cos_w);
    s_e   = ACC_W'(sin_w);
    sum_r = acc_r_q + (xr_e * c_e - xi_e * s_e);
    sum_i = acc_i_q + (xr_e * s_e + xi_e * c_e);
  end
  // next-state and datapath updates for IDLE / RUN / OUT
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    idx_d   = idx_q;
    xr_d    = xr_q;
    xi_d    = xi_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (state_q == IDLE && bus.in_valid) begin
      xr_d    = bus.in_r;
      xi_d    = bus.in_i;
      acc_r_d = '0;
      acc_i_d = '0;
      k_d     = '0;
      n_d     = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      acc_r_d = sum_r;
      acc_i_d = sum_i;
      n_d     = (n_q == 2'd3) ? n_q : n_q + 2'd1;
      if (n_q == 2'd3) begin
        out_r_d = OUT_W'(sum_r >>> TW_FRAC);
        out_i_d = OUT_W'(sum_i >>> TW_FRAC);
        idx_d   = k_q;
        last_d  = (k_q == 2'd3);
        valid_d = 1'b1;
        state_d = OUT;
      end
    end else if (state_q == OUT && bus.out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      state_d = (k_q == 2'd3) ? IDLE : RUN;
      k_d     = (k_q == 2'd3) ? k_q : k_q + 2'd1;
      n_d     = '0;
      acc_r_d = '0;
      acc_i_d = '0;
    end
  end
  // state and datapath registers; reset aborts any vector in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      xr_q    <= '0;
      xi_q    <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
      out_r_q <= '0;
      out_i_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      xr_q    <= xr_d;
      xi_q    <= xi_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_qft_row_sequencer.sv
// tb_qft_row_sequencer: table vectors, corner sequences and random vectors against a complex-arithmetic QFT model
module tb_qft_row_sequencer;
  typedef logic [3:0][7:0]  vec8_t;
  typedef logic [3:0][12:0] vec13_t;
  typedef struct packed {
    vec8_t  xr;
    vec8_t  xi;
    vec13_t er;
    vec13_t ei;
    logic [2:0] stall;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int errors = 0;
  int checks = 0;
  qft_row_sequencer_if #(.IN_W(8), .OUT_W(13)) bus ();
  qft_row_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy_o(busy));
  always #5 clk = ~clk;
  rec_t tbl[5];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic vec8_t p8(input int a, input int b, input int c, input int d);
    vec8_t v;
    v[0] = 8'(a); v[1] = 8'(b); v[2] = 8'(c); v[3] = 8'(d);
    return v;
  endfunction
  function automatic vec13_t p13(input int a, input int b, input int c, input int d);
    vec13_t v;
    v[0] = 13'(a); v[1] = 13'(b); v[2] = 13'(c); v[3] = 13'(d);
    return v;
  endfunction
  // y[k] = sum_n x[n] * i^(k*n), unnormalized
  function automatic void model(input vec8_t xr, input vec8_t xi, output vec13_t er, output vec13_t ei);
    for (int k = 0; k < 4; k++) begin
      int sr = 0;
      int si = 0;
      for (int n = 0; n < 4; n++) begin
        int a = $signed(xr[n]);
        int b = $signed(xi[n]);
        int p = (k * n) % 4;
        if (p == 0) begin sr += a; si += b; end
        else if (p == 1) begin sr -= b; si += a; end
        else if (p == 2) begin sr -= a; si -= b; end
        else begin sr += b; si -= a; end
      end
      er[k] = 13'(sr);
      ei[k] = 13'(si);
    end
  endfunction
  task automatic send(input vec8_t xr, input vec8_t xi);
    int c = 0;
    @(negedge clk);
    while (!bus.in_ready && c < 50) begin c++; @(negedge clk); end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_r = xr;
    bus.in_i = xi;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic collect(input vec13_t er, input vec13_t ei, input int stall);
    for (int k = 0; k < 4; k++) begin
      int c = 0;
      @(negedge clk);
      while (!bus.out_valid && c < 20) begin c++; @(negedge clk); end
      if (!bus.out_valid) begin
        chk("out_valid_timeout", 0, 1);
        return;
      end
      chk("row_latency", c, 4);
      chk("out_r", $signed(bus.out_r), $signed(er[k]));
      chk("out_i", $signed(bus.out_i), $signed(ei[k]));
      chk("out_idx", int'(bus.out_idx), k);
      chk("out_last", int'(bus.out_last), int'(k == 3));
      chk("in_ready_busy", int'(bus.in_ready), 0);
      if (stall == k) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_valid", int'(bus.out_valid), 1);
          chk("stall_r", $signed(bus.out_r), $signed(er[k]));
          chk("stall_i", $signed(bus.out_i), $signed(ei[k]));
          chk("stall_idx", int'(bus.out_idx), k);
          chk("stall_in_ready", int'(bus.in_ready), 0);
          chk("stall_busy", int'(busy), 1);
        end
        bus.out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("end_in_ready", int'(bus.in_ready), 1);
    chk("end_out_valid", int'(bus.out_valid), 0);
    chk("end_out_last", int'(bus.out_last), 0);
  endtask
  initial begin
    vec8_t xr, xi, br, bi;
    vec13_t er, ei;
    int vhits;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_r = '0;
    bus.in_i = '0;
    tbl[0] = '{xr: p8(1, 0, 0, 0), xi: p8(0, 0, 0, 0), er: p13(1, 1, 1, 1), ei: p13(0, 0, 0, 0), stall: 3'd4};
    tbl[1] = '{xr: p8(0, 1, 0, 0), xi: p8(0, 0, 0, 0), er: p13(1, 0, -1, 0), ei: p13(0, 1, 0, -1), stall: 3'd4};
    tbl[2] = '{xr: p8(1, 1, 1, 1), xi: p8(0, 0, 0, 0), er: p13(4, 0, 0, 0), ei: p13(0, 0, 0, 0), stall: 3'd4};
    tbl[3] = '{xr: p8(-128, -128, -128, -128), xi: p8(0, 0, 0, 0), er: p13(-512, 0, 0, 0), ei: p13(0, 0, 0, 0), stall: 3'd4};
    tbl[4] = '{xr: p8(127, 0, 0, 0), xi: p8(127, 0, 0, 0), er: p13(127, 127, 127, 127), ei: p13(127, 127, 127, 127), stall: 3'd1};
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_r", $signed(bus.out_r), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      send(tbl[t].xr, tbl[t].xi);
      collect(tbl[t].er, tbl[t].ei, int'(tbl[t].stall));
    end
    xr = p8(3, -7, 20, 1);
    xi = p8(-5, 9, 0, 44);
    br = p8(0, 1, 0, 0);
    bi = p8(0, 0, 0, 0);
    send(xr, xi);
    bus.in_r = br;
    bus.in_i = bi;
    bus.in_valid = 1'b1;
    model(xr, xi, er, ei);
    collect(er, ei, 4);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model(br, bi, er, ei);
    collect(er, ei, 4);
    send(p8(9, 9, 9, 9), p8(1, 2, 3, 4));
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_r", $signed(bus.out_r), 0);
    chk("abort_out_i", $signed(bus.out_i), 0);
    chk("abort_out_idx", int'(bus.out_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vhits = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vhits += int'(bus.out_valid);
    end
    chk("no_stale_output", vhits, 0);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    for (int r = 0; r < 12; r++) begin
      for (int n = 0; n < 4; n++) begin
        xr[n] = 8'($urandom);
        xi[n] = 8'($urandom);
      end
      model(xr, xi, er, ei);
      send(xr, xi);
      collect(er, ei, int'($urandom_range(0, 5)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
